// File: rtl/bit_selection_ram_port.sv
`default_nettype none
// ============================================================================
// Module   : bit_selection_ram_port
// Purpose  : Write-side lane alignment and memory-clear sequencing for one
//            port of the 4x512x20 simulation RAM macro.
// Revision : 1.0 - initial release
// ============================================================================
module bit_selection_ram_port #(
   parameter int         ADDR_W        = 11,
   parameter bit         INIT_CLEAR    = 1'b1,
   parameter logic [2:0] CONFIG_1BIT   = 3'd1,
   parameter logic [2:0] CONFIG_2BIT   = 3'd2,
   parameter logic [2:0] CONFIG_5BIT   = 3'd3,
   parameter logic [2:0] CONFIG_10BIT  = 3'd4,
   parameter logic [2:0] CONFIG_20BIT  = 3'd5,
   parameter logic [2:0] CONFIG_40BIT  = 3'd6,
   parameter logic [2:0] CONFIG_80BIT  = 3'd7
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [2:0]        output_config_i,
   input  logic              we_i,
   input  logic              re_i,
   input  logic              wt_i,
   input  logic              clear_req_i,
   input  logic [15:0]       addr_i,
   input  logic [19:0]       wrdata_i,
   input  logic [19:0]       bitmask_i,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic              ram_we_o,
   output logic              ram_re_o,
   output logic [19:0]       ram_wrdata_o,
   output logic [19:0]       ram_bwe_o,
   output logic              busy_o
);

   typedef enum logic [0:0] {
      S_RUN   = 1'b0,
      S_CLEAR = 1'b1
   } state_t;

   localparam state_t            c_RESET_STATE = INIT_CLEAR ? S_CLEAR : S_RUN;
   localparam logic [ADDR_W-1:0] c_CNT_MAX     = {ADDR_W{1'b1}};

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
   logic [ADDR_W-1:0] r_ram_addr, w_addr_nxt;
   logic              r_ram_we, w_we_nxt;
   logic              r_ram_re, w_re_nxt;
   logic [19:0]       r_ram_wrdata, w_wrdata_nxt;
   logic [19:0]       r_ram_bwe, w_bwe_nxt;

   logic [4:0]        w_shift;
   logic [19:0]       w_width_mask;
   logic [19:0]       w_lane_data;
   logic [19:0]       w_lane_bwe;
   logic              w_unused;

   // Lane origin skips the unused bits 4, 9, 14 and 19 of the macro word.
   always_comb begin
      w_shift      = 5'd0;
      w_width_mask = 20'h00000;
      case (output_config_i)
         CONFIG_1BIT: begin
            w_width_mask = 20'h00001;
            w_shift      = {1'b0, addr_i[4:1]} + {3'b000, addr_i[4:3]};
         end
         CONFIG_2BIT: begin
            w_width_mask = 20'h00003;
            w_shift      = {1'b0, addr_i[4:2], 1'b0} + {3'b000, addr_i[4:3]};
         end
         CONFIG_5BIT: begin
            w_width_mask = 20'h0001F;
            w_shift      = {1'b0, addr_i[4:3], 2'b00} + {3'b000, addr_i[4:3]};
         end
         CONFIG_10BIT: begin
            w_width_mask = 20'h003FF;
            w_shift      = addr_i[4] ? 5'd10 : 5'd0;
         end
         CONFIG_20BIT, CONFIG_40BIT, CONFIG_80BIT: begin
            w_width_mask = 20'hFFFFF;
         end
         default: begin
            w_width_mask = 20'h00000;
         end
      endcase
   end

   assign w_lane_data = (wrdata_i  & w_width_mask) << w_shift;
   assign w_lane_bwe  = (bitmask_i & w_width_mask) << w_shift;

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_addr_nxt   = r_ram_addr;
      w_we_nxt     = 1'b0;
      w_re_nxt     = 1'b0;
      w_wrdata_nxt = 20'h00000;
      w_bwe_nxt    = 20'h00000;
      case (r_state)
         S_CLEAR: begin
            w_we_nxt   = 1'b1;
            w_bwe_nxt  = 20'hFFFFF;
            w_addr_nxt = r_cnt;
            w_cnt_nxt  = r_cnt + 1'b1;
            if (r_cnt == c_CNT_MAX) begin
               w_state_nxt = S_RUN;
               w_cnt_nxt   = '0;
            end
         end
         S_RUN: begin
            if (clear_req_i) begin
               w_state_nxt = S_CLEAR;
            end else begin
               w_we_nxt = we_i;
               w_re_nxt = re_i | (we_i & wt_i);
               if (we_i | re_i) begin
                  w_addr_nxt = addr_i[ADDR_W+4:5];
               end
               if (we_i) begin
                  w_wrdata_nxt = w_lane_data;
                  w_bwe_nxt    = w_lane_bwe;
               end
            end
         end
         default: begin
            w_state_nxt = S_RUN;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= c_RESET_STATE;
         r_cnt        <= '0;
         r_ram_addr   <= '0;
         r_ram_we     <= 1'b0;
         r_ram_re     <= 1'b0;
         r_ram_wrdata <= 20'h00000;
         r_ram_bwe    <= 20'h00000;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_ram_addr   <= w_addr_nxt;
         r_ram_we     <= w_we_nxt;
         r_ram_re     <= w_re_nxt;
         r_ram_wrdata <= w_wrdata_nxt;
         r_ram_bwe    <= w_bwe_nxt;
      end
   end

   assign ram_addr_o   = r_ram_addr;
   assign ram_we_o     = r_ram_we;
   assign ram_re_o     = r_ram_re;
   assign ram_wrdata_o = r_ram_wrdata;
   assign ram_bwe_o    = r_ram_bwe;
   assign busy_o       = (r_state == S_CLEAR);

   // Bit 0 and any address bits above the word field carry no write-side meaning.
   assign w_unused = ^addr_i;

endmodule
`default_nettype wire

// File: tb/tb_bit_selection_ram_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_selection_ram_port
// Purpose  : Directed self-checking bench for bit_selection_ram_port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_selection_ram_port;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [2:0]  output_config_i;
   logic        we_i, re_i, wt_i, clear_req_i;
   logic [15:0] addr_i;
   logic [19:0] wrdata_i, bitmask_i;
   logic [10:0] ram_addr_o;
   logic        ram_we_o, ram_re_o, busy_o;
   logic [19:0] ram_wrdata_o, ram_bwe_o;

   int n_checks = 0;
   int n_fail   = 0;

   bit_selection_ram_port dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .output_config_i (output_config_i),
      .we_i            (we_i),
      .re_i            (re_i),
      .wt_i            (wt_i),
      .clear_req_i     (clear_req_i),
      .addr_i          (addr_i),
      .wrdata_i        (wrdata_i),
      .bitmask_i       (bitmask_i),
      .ram_addr_o      (ram_addr_o),
      .ram_we_o        (ram_we_o),
      .ram_re_o        (ram_re_o),
      .ram_wrdata_o    (ram_wrdata_o),
      .ram_bwe_o       (ram_bwe_o),
      .busy_o          (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Drive one request, let it cross one edge; outputs are then valid.
   task automatic apply(input logic [2:0] cfg, input logic we, input logic re, input logic wt,
                        input logic clr, input logic [15:0] a, input logic [19:0] wd,
                        input logic [19:0] bm);
      output_config_i = cfg;
      we_i = we; re_i = re; wt_i = wt; clear_req_i = clr;
      addr_i = a; wrdata_i = wd; bitmask_i = bm;
      step();
   endtask

   initial begin
      rst_i = 1'b1;
      output_config_i = 3'd1;
      we_i = 1'b1; re_i = 1'b1; wt_i = 1'b1; clear_req_i = 1'b0;
      addr_i = 16'hFFFF; wrdata_i = 20'hFFFFF; bitmask_i = 20'hFFFFF;
      #1;
      check_value("reset_busy", {31'd0, busy_o}, 32'd1);
      check_value("reset_ctl", {30'd0, ram_we_o, ram_re_o}, 32'd0);
      check_value("reset_addr", {21'd0, ram_addr_o}, 32'd0);
      check_value("reset_bwe", {12'd0, ram_bwe_o}, 32'd0);
      step();
      step();
      rst_i = 1'b0;

      // Clear sequence; user requests and a clear pulse must be ignored.
      for (int k = 1; k <= 2048; k++) begin
         clear_req_i = (k == 10);
         step();
         check_value("clr_addr", {21'd0, ram_addr_o}, 32'(k - 1));
         check_value("clr_ctl", {ram_we_o, ram_re_o, ram_bwe_o, ram_wrdata_o},
                     {1'b1, 1'b0, 20'hFFFFF, 20'h00000});
         check_value("clr_busy", {31'd0, busy_o}, (k < 2048) ? 32'd1 : 32'd0);
      end
      we_i = 1'b0; re_i = 1'b0; wt_i = 1'b0; clear_req_i = 1'b0;
      step();
      check_value("post_clr_we", {31'd0, ram_we_o}, 32'd0);
      check_value("post_clr_addr", {21'd0, ram_addr_o}, 32'd2047);
      check_value("post_clr_busy", {31'd0, busy_o}, 32'd0);

      apply(3'd1, 1, 0, 0, 0, 16'h0009, 20'h00001, 20'h00001);
      check_value("b1_data", {12'd0, ram_wrdata_o}, 32'h00020);
      check_value("b1_bwe", {12'd0, ram_bwe_o}, 32'h00020);
      check_value("b1_addr", {21'd0, ram_addr_o}, 32'd0);
      check_value("b1_ctl", {30'd0, ram_we_o, ram_re_o}, 32'd2);

      apply(3'd2, 1, 0, 0, 0, 16'h003C, 20'h00002, 20'h00003);
      check_value("b2_data", {12'd0, ram_wrdata_o}, 32'h40000);
      check_value("b2_bwe", {12'd0, ram_bwe_o}, 32'h60000);
      check_value("b2_addr", {21'd0, ram_addr_o}, 32'd1);

      apply(3'd3, 1, 0, 0, 0, 16'h0058, 20'hFFFF5, 20'hFFFFF);
      check_value("b5_data", {12'd0, ram_wrdata_o}, 32'hA8000);
      check_value("b5_bwe", {12'd0, ram_bwe_o}, 32'hF8000);
      check_value("b5_addr", {21'd0, ram_addr_o}, 32'd2);

      apply(3'd4, 1, 0, 0, 0, 16'h0030, 20'h003FF, 20'h000F0);
      check_value("b10_data", {12'd0, ram_wrdata_o}, 32'hFFC00);
      check_value("b10_bwe", {12'd0, ram_bwe_o}, 32'h3C000);
      check_value("b10_addr", {21'd0, ram_addr_o}, 32'd1);

      apply(3'd5, 1, 0, 1, 0, 16'h0FE0, 20'h12345, 20'hABCDE);
      check_value("b20_data", {12'd0, ram_wrdata_o}, 32'h12345);
      check_value("b20_bwe", {12'd0, ram_bwe_o}, 32'hABCDE);
      check_value("b20_addr", {21'd0, ram_addr_o}, 32'h7F);
      check_value("wt_re", {30'd0, ram_we_o, ram_re_o}, 32'd3);

      apply(3'd1, 1, 0, 0, 0, 16'h001E, 20'h00001, 20'h00000);
      check_value("b1_top_data", {12'd0, ram_wrdata_o}, 32'h40000);
      check_value("b1_top_bwe", {12'd0, ram_bwe_o}, 32'h00000);

      apply(3'd0, 1, 0, 0, 0, 16'h0000, 20'hFFFFF, 20'hFFFFF);
      check_value("undef_bwe", {12'd0, ram_bwe_o}, 32'h00000);

      apply(3'd5, 0, 1, 0, 0, 16'h0040, 20'hFFFFF, 20'hFFFFF);
      check_value("rd_ctl", {30'd0, ram_we_o, ram_re_o}, 32'd1);
      check_value("rd_bwe", {12'd0, ram_bwe_o}, 32'h00000);
      check_value("rd_data", {12'd0, ram_wrdata_o}, 32'h00000);
      check_value("rd_addr", {21'd0, ram_addr_o}, 32'd2);

      apply(3'd5, 0, 0, 1, 0, 16'h0700, 20'hFFFFF, 20'hFFFFF);
      check_value("idle_ctl", {30'd0, ram_we_o, ram_re_o}, 32'd0);
      check_value("idle_addr", {21'd0, ram_addr_o}, 32'd2);

      apply(3'd5, 1, 1, 0, 0, 16'h00A0, 20'h0000F, 20'h000F0);
      check_value("wr_rd_ctl", {30'd0, ram_we_o, ram_re_o}, 32'd3);
      check_value("wr_rd_addr", {21'd0, ram_addr_o}, 32'd5);

      // Clear request with a write in the same cycle: write dropped.
      apply(3'd5, 1, 0, 0, 1, 16'h0100, 20'hFFFFF, 20'hFFFFF);
      check_value("clrreq_we", {31'd0, ram_we_o}, 32'd0);
      check_value("clrreq_bwe", {12'd0, ram_bwe_o}, 32'h00000);
      check_value("clrreq_busy", {31'd0, busy_o}, 32'd1);
      check_value("clrreq_addr", {21'd0, ram_addr_o}, 32'd5);
      we_i = 1'b0; clear_req_i = 1'b0;
      for (int k = 1; k <= 100; k++) step();
      check_value("clr2_addr", {21'd0, ram_addr_o}, 32'd99);

      rst_i = 1'b1;
      #1;
      check_value("arst_ctl", {ram_we_o, ram_re_o, ram_bwe_o, ram_wrdata_o}, 42'd0);
      check_value("arst_addr", {21'd0, ram_addr_o}, 32'd0);
      check_value("arst_busy", {31'd0, busy_o}, 32'd1);
      step();
      rst_i = 1'b0;
      step();
      check_value("restart_addr0", {21'd0, ram_addr_o}, 32'd0);
      check_value("restart_we", {31'd0, ram_we_o}, 32'd1);
      step();
      check_value("restart_addr1", {21'd0, ram_addr_o}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
